// File: rtl/fpu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fpu_pkg : shared types and constants for the FPU compare issue path.
// Rev 1.0
// ------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'b000,
    CMP_NE = 3'b001,
    CMP_LE = 3'b010,
    CMP_GE = 3'b011,
    CMP_LT = 3'b100,
    CMP_GT = 3'b101
  } cmp_op_t;

  // Encodings above this value are illegal compare kinds.
  localparam logic [2:0] c_FUNCT_LEGAL_MAX = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_ISSUE1 = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } cmp_issue_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_cmp_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// fpu_cmp_decode : maps decode funct to a compare op, flags illegal kinds.
// Rev 1.0
// ------------------------------------------------------------------
module fpu_cmp_decode
  import fpu_pkg::*;
(
  input  logic [2:0] i_funct,
  output cmp_op_t    o_op,
  output logic       o_illegal
);

  always_comb begin
    o_illegal = (i_funct > c_FUNCT_LEGAL_MAX);
    o_op      = o_illegal ? CMP_EQ : cmp_op_t'(i_funct);
  end

endmodule
`default_nettype wire

// File: rtl/fpu_cmp_issue.sv
`default_nettype none
// ------------------------------------------------------------------
// fpu_cmp_issue : issue/retire adapter in front of the FPU compare unit.
// Define FPU_CMP_WATCHDOG_EN to bound the WAIT state. Rev 1.0
// ------------------------------------------------------------------
module fpu_cmp_issue
  import fpu_pkg::*;
#(
  parameter int RD_W = 5
`ifdef FPU_CMP_WATCHDOG_EN
  , parameter int WDOG_CYC = 8
`endif
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [2:0]      req_funct,
  input  logic [RD_W-1:0] req_rd,
  output logic            cmp_data_valid,
  output logic [31:0]     cmp_a_data,
  output logic [31:0]     cmp_b_data,
  output logic [2:0]      cmp_op_data,
  input  logic [31:0]     cmp_c_data,
  input  logic            cmp_c_valid,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            wb_err
);

  cmp_issue_state_t r_state, w_next;
  logic [31:0]      r_a, r_b;
  cmp_op_t          r_op;
  logic [RD_W-1:0]  r_rd;
  logic             r_data, r_err;
  logic             w_accept, w_capture, w_wdog_fire;
  cmp_op_t          w_dec_op;
  logic             w_dec_illegal;
  logic             w_unused_c_hi;

  // Only bit 0 of the compare result carries information.
  assign w_unused_c_hi = ^cmp_c_data[31:1];

  fpu_cmp_decode u_decode (
    .i_funct   (req_funct),
    .o_op      (w_dec_op),
    .o_illegal (w_dec_illegal)
  );

`ifdef FPU_CMP_WATCHDOG_EN
  localparam int c_WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  logic [c_WDOG_W-1:0] r_wdog;

  always_ff @(posedge aclk) begin
    if (aresetn || (r_state != ST_WAIT)) r_wdog <= '0;
    else                                 r_wdog <= r_wdog + 1'b1;
  end
`endif

  always_ff @(posedge aclk) begin
    if (aresetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_wdog_fire    = 1'b0;
    req_ready      = (r_state == ST_IDLE) && !aresetn;
    cmp_data_valid = 1'b0;
    wb_valid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && !aresetn) begin
          w_accept = 1'b1;
          w_next   = w_dec_illegal ? ST_RESP : ST_ISSUE0;
        end
      end
      // data_valid must be high for exactly these two states.
      ST_ISSUE0: begin
        cmp_data_valid = 1'b1;
        w_next         = ST_ISSUE1;
      end
      ST_ISSUE1: begin
        cmp_data_valid = 1'b1;
        w_next         = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmp_c_valid) begin
          w_capture = 1'b1;
          w_next    = ST_RESP;
        end
`ifdef FPU_CMP_WATCHDOG_EN
        else if (r_wdog == c_WDOG_W'(WDOG_CYC - 1)) begin
          w_wdog_fire = 1'b1;
          w_next      = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= CMP_EQ;
      r_rd   <= '0;
      r_data <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= req_rs1;
        r_b    <= req_rs2;
        r_op   <= w_dec_op;
        r_rd   <= req_rd;
        r_data <= 1'b0;
        r_err  <= w_dec_illegal;
      end
      if (w_capture) begin
        r_data <= cmp_c_data[0];
        r_err  <= 1'b0;
      end
      if (w_wdog_fire) begin
        r_data <= 1'b0;
        r_err  <= 1'b1;
      end
    end
  end

  assign cmp_a_data  = r_a;
  assign cmp_b_data  = r_b;
  assign cmp_op_data = r_op;
  assign wb_rd       = r_rd;
  assign wb_data     = {31'b0, r_data};
  assign wb_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmp_issue.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fpu_cmp_issue : directed bench with a behavioural compare-unit stub
// and a transaction-level reference model checked every cycle. Rev 1.0
// ------------------------------------------------------------------
module tb_fpu_cmp_issue;

  localparam int RD_W = 5;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [31:0]     req_rs1 = '0;
  logic [31:0]     req_rs2 = '0;
  logic [2:0]      req_funct = '0;
  logic [RD_W-1:0] req_rd = '0;
  logic            cmp_data_valid;
  logic [31:0]     cmp_a_data, cmp_b_data;
  logic [2:0]      cmp_op_data;
  logic [31:0]     cmp_c_data;
  logic            cmp_c_valid;
  logic            wb_valid;
  logic            wb_ready = 1'b1;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            wb_err;

  int n_vec = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  fpu_cmp_issue #(.RD_W(RD_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct(req_funct), .req_rd(req_rd),
    .cmp_data_valid(cmp_data_valid), .cmp_a_data(cmp_a_data), .cmp_b_data(cmp_b_data),
    .cmp_op_data(cmp_op_data), .cmp_c_data(cmp_c_data), .cmp_c_valid(cmp_c_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err)
  );

  // IEEE single-precision compare; any NaN makes everything false except NE.
  function automatic bit fcmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    bit     na, nb, eq, lt;
    longint ka, kb;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (na || nb) return (f == 3'b001);
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    eq = (ka == kb);
    lt = (ka < kb);
    case (f)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b010:  return lt || eq;
      3'b011:  return !lt;
      3'b100:  return lt;
      3'b101:  return !lt && !eq;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- compare-unit stub ----------------
  int   stub_delay = 0;
  bit   stub_never = 0;
  logic stub_stray = 1'b0;
  logic s_pend = 1'b0, s_res = 1'b0, s_dv_q = 1'b0;
  int   s_cnt = 0;

  always @(posedge aclk) begin
    if (aresetn) begin
      s_pend <= 1'b0; s_dv_q <= 1'b0; s_cnt <= 0; s_res <= 1'b0;
    end else begin
      s_dv_q <= cmp_data_valid;
      if (s_pend) begin
        if (s_cnt == 0) s_pend <= 1'b0;
        else            s_cnt <= s_cnt - 1;
      end
      if (cmp_data_valid && s_dv_q) begin
        s_pend <= 1'b1;
        s_cnt  <= stub_delay;
        s_res  <= fcmp(cmp_a_data, cmp_b_data, cmp_op_data);
      end
    end
  end
  assign cmp_c_valid = (s_pend && (s_cnt == 0) && !stub_never) || stub_stray;
  assign cmp_c_data  = {31'h1234_5678, s_res};

  // ---------------- transaction-level reference model ----------------
  int         m_cyc = 0, m_acc = -100;
  bit         m_on = 0, m_busy = 0, m_legal = 0, m_resp = 0, m_zero = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;
  logic [RD_W-1:0] m_rd = '0;
  logic        m_data = 1'b0, m_err = 1'b0;

  always @(posedge aclk) begin
    m_cyc <= m_cyc + 1;
    if (aresetn) begin
      m_busy <= 0; m_resp <= 0; m_zero <= 1;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1; m_zero <= 0; m_acc <= m_cyc;
        m_legal <= (req_funct <= 3'd5);
        m_a <= req_rs1; m_b <= req_rs2; m_op <= req_funct; m_rd <= req_rd;
        m_resp <= (req_funct > 3'd5);
        m_data <= fcmp(req_rs1, req_rs2, req_funct);
        m_err  <= (req_funct > 3'd5);
      end
    end else if (m_resp) begin
      if (wb_ready) m_busy <= 0;
    end else if (m_cyc >= m_acc + 3) begin
      if (cmp_c_valid) m_resp <= 1;
`ifdef FPU_CMP_WATCHDOG_EN
      else if (m_cyc == m_acc + 3 + 8 - 1) begin
        m_resp <= 1; m_data <= 1'b0; m_err <= 1'b1;
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  always @(negedge aclk) begin
    if (m_on) begin
      chk("req_ready", req_ready, !aresetn && !m_busy);
      chk("cmp_data_valid", cmp_data_valid,
          m_busy && m_legal && !m_resp && (m_cyc == m_acc + 1 || m_cyc == m_acc + 2));
      chk("wb_valid", wb_valid, m_busy && m_resp);
      if (m_busy && m_resp) begin
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_data", wb_data, {31'b0, m_data});
        chk("wb_err", wb_err, m_err);
      end
      if (m_busy && m_legal && !m_resp) begin
        chk("cmp_a_data", cmp_a_data, m_a);
        chk("cmp_b_data", cmp_b_data, m_b);
        chk("cmp_op_data", cmp_op_data, m_op);
      end
      if (m_zero) begin
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_cmp_a", cmp_a_data, 0);
        chk("rst_cmp_b", cmp_b_data, 0);
        chk("rst_cmp_op", cmp_op_data, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Present a request until accepted; returns the accept cycle, ends #1 into N+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic [RD_W-1:0] rd, output int n);
    bit got = 0;
    req_rs1 = a; req_rs2 = b; req_funct = f; req_rd = rd; req_valid = 1'b1;
    n = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge aclk);
      if (req_ready) begin got = 1; n = m_cyc; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    step(1);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) until wb_valid is seen at a negedge; returns that cycle.
  task automatic wait_wb(input int budget, output int c);
    bit got = 0;
    c = -1;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge aclk);
      if (wb_valid) begin got = 1; c = m_cyc; end
    end
    if (!got) chk("wb_timeout", 0, 1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        exp;
  } vec_t;

  vec_t tbl[9];
  int   n, c;

  initial begin
    tbl[0] = '{32'h3F800000, 32'h3F800000, 3'b011, 1'b1}; // 1 GE 1
    tbl[1] = '{32'hBF800000, 32'h3F800000, 3'b101, 1'b0}; // -1 GT 1
    tbl[2] = '{32'h3F800000, 32'h40000000, 3'b001, 1'b1}; // 1 NE 2
    tbl[3] = '{32'h40000000, 32'h3F800000, 3'b010, 1'b0}; // 2 LE 1
    tbl[4] = '{32'h7FC00000, 32'h3F800000, 3'b100, 1'b0}; // NaN LT 1
    tbl[5] = '{32'h7FC00000, 32'h7FC00000, 3'b001, 1'b1}; // NaN NE NaN
    tbl[6] = '{32'hC0000000, 32'hBF800000, 3'b011, 1'b0}; // -2 GE -1
    tbl[7] = '{32'hC0000000, 32'hBF800000, 3'b100, 1'b1}; // -2 LT -1
    tbl[8] = '{32'h3F800000, 32'h3F800000, 3'b110, 1'b0}; // illegal 110

    // Reset held for three cycles.
    @(posedge aclk); #1; m_on = 1;
    @(negedge aclk);
    chk("lit_rst_ready", req_ready, 0);
    chk("lit_rst_dv", cmp_data_valid, 0);
    chk("lit_rst_wbv", wb_valid, 0);
    step(2);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("lit_release_ready", req_ready, 1);
    step(1);

    // LT: -1 < 1, exact cycle-by-cycle latency.
    issue(32'hBF800000, 32'h3F800000, 3'b100, 5'd7, n);
    @(negedge aclk); chk("lit_lt_dv1", cmp_data_valid, 1); chk("lit_lt_op", cmp_op_data, 3'b100);
    @(negedge aclk); chk("lit_lt_dv2", cmp_data_valid, 1);
    @(negedge aclk); chk("lit_lt_dv3", cmp_data_valid, 0); chk("lit_lt_wbv3", wb_valid, 0);
    @(negedge aclk);
    chk("lit_lt_wbv4", wb_valid, 1); chk("lit_lt_rd", wb_rd, 7);
    chk("lit_lt_data", wb_data, 32'h1); chk("lit_lt_err", wb_err, 0);
    step(1);

    // EQ: +0 vs -0, with a stray result pulse during ISSUE0.
    issue(32'h00000000, 32'h80000000, 3'b000, 5'd2, n);
    stub_stray = 1'b1; step(1); stub_stray = 1'b0;
    wait_wb(20, c);
    chk("lit_eq_data", wb_data, 32'h1);
    chk("lit_eq_latency", c - n, 4);
    step(1);

    // Stray result while idle must be ignored.
    stub_stray = 1'b1; step(1); stub_stray = 1'b0; step(1);

    // Illegal funct 111.
    issue(32'h3F800000, 32'h3F800000, 3'b111, 5'd3, n);
    @(negedge aclk);
    chk("lit_ill_wbv", wb_valid, 1); chk("lit_ill_data", wb_data, 0);
    chk("lit_ill_err", wb_err, 1); chk("lit_ill_dv", cmp_data_valid, 0);
    chk("lit_ill_rd", wb_rd, 3);
    step(1);

    // Table of compare kinds with varying result latency.
    foreach (tbl[i]) begin
      stub_delay = i % 3;
      issue(tbl[i].a, tbl[i].b, tbl[i].f, RD_W'(i + 16), n);
      wait_wb(30, c);
      chk("lit_tbl_data", wb_data, {31'b0, tbl[i].exp});
      step(1);
    end
    stub_delay = 0;

    // Backpressure with a second request pending.
    wb_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, 3'b100, 5'd9, n);
    req_rs1 = 32'h40000000; req_rs2 = 32'h3F800000; req_funct = 3'b101;
    req_rd = 5'd11; req_valid = 1'b1;
    wait_wb(20, c);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge aclk);
      chk("lit_bp_ready", req_ready, 0); chk("lit_bp_wbv", wb_valid, 1);
      chk("lit_bp_rd", wb_rd, 9); chk("lit_bp_data", wb_data, 32'h1);
    end
    step(1);
    wb_ready = 1'b1;
    @(negedge aclk); chk("lit_hs_ready", req_ready, 0);
    step(1);
    @(negedge aclk); chk("lit_second_ready", req_ready, 1);
    step(1);
    req_valid = 1'b0;
    @(negedge aclk); chk("lit_second_dv", cmp_data_valid, 1);
    wait_wb(20, c);
    chk("lit_second_rd", wb_rd, 11); chk("lit_second_data", wb_data, 32'h1);
    step(1);

    // Reset asserted during ISSUE1.
    issue(32'h3F800000, 32'h3F800000, 3'b000, 5'd5, n);
    step(1);
    aresetn = 1'b1;
    @(negedge aclk); chk("lit_abort_dv_before", cmp_data_valid, 1);
    step(1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("lit_abort_dv", cmp_data_valid, 0); chk("lit_abort_wbv", wb_valid, 0);
    chk("lit_abort_ready", req_ready, 1);
    step(3);

`ifdef FPU_CMP_WATCHDOG_EN
    // Compare unit never answers: watchdog after eight WAIT cycles.
    stub_never = 1;
    issue(32'h3F800000, 32'h3F800000, 3'b000, 5'd4, n);
    wait_wb(40, c);
    chk("lit_wdog_latency", c - n, 11);
    chk("lit_wdog_err", wb_err, 1); chk("lit_wdog_data", wb_data, 0);
    step(1);
    stub_never = 0;
`else
    // Long result latency: WAIT has no limit.
    stub_delay = 12;
    issue(32'h3F800000, 32'h3F800000, 3'b010, 5'd4, n);
    wait_wb(40, c);
    chk("lit_long_latency", c - n, 16);
    chk("lit_long_err", wb_err, 0); chk("lit_long_data", wb_data, 32'h1);
    step(1);
    stub_delay = 0;
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_cmp_issue.md
# fpu_cmp_issue

Issue/retire adapter sitting directly upstream of the FPU compare unit. Accepts a float-compare request from decode, drives the compare unit's two-cycle `data_valid` protocol with stable operands, and captures the 1-bit result. Returns the zero-extended result with the destination register tag to integer writeback through a valid/ready handshake.

## Interface
Parameters:
- `RD_W`, default 5: width of the destination register tag.
- `WDOG_CYC`, default 8: watchdog limit in WAIT cycles. Used only when `FPU_CMP_WATCHDOG_EN` is defined.

Ports:
- `aclk`  in  1  clock. All logic is on the rising edge.
- `aresetn`  in  1  reset, synchronous and active-high: `aresetn`=1 resets the block.
- `req_valid`  in  1  request from decode.
- `req_ready`  out  1  block can accept a request.
- `req_rs1`, `req_rs2`  in  32  single-precision operands.
- `req_funct`  in  3  compare kind: 000 EQ, 001 NE, 010 LE, 011 GE, 100 LT, 101 GT; 110 and 111 are illegal.
- `req_rd`  in  `RD_W`  destination tag.
- `cmp_data_valid`  out  1  data_valid to the compare unit.
- `cmp_a_data`, `cmp_b_data`  out  32  operands to the compare unit.
- `cmp_op_data`  out  3  op to the compare unit.
- `cmp_c_data`  in  32  compare result; only bit 0 is meaningful.
- `cmp_c_valid`  in  1  compare result valid.
- `wb_valid`  out  1  writeback valid.
- `wb_ready`  in  1  writeback accepted.
- `wb_rd`  out  `RD_W`  destination tag.
- `wb_data`  out  32  result, {31'b0, bit}.
- `wb_err`  out  1  illegal funct or watchdog expiry; qualified by `wb_valid`.

## Operation
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP.
- `req_ready` = (state==IDLE) & !`aresetn`.
- IDLE:
  - On `req_valid`&`req_ready`, register rs1, rs2, funct and rd.
  - If funct is legal, go to ISSUE0.
  - If funct is illegal, go to RESP with result 0 and `wb_err`=1. The compare unit is not touched.
- ISSUE0 and ISSUE1:
  - `cmp_data_valid`=1 for exactly these two cycles, never more.
  - The compare unit re-captures if `data_valid` stays high after it finishes, so a third cycle is forbidden.
  - `cmp_a_data`, `cmp_b_data` and `cmp_op_data` are held from the registered copies and stay stable through WAIT.
- WAIT:
  - `cmp_data_valid`=0.
  - When `cmp_c_valid`=1, capture `cmp_c_data[0]` into `wb_data[0]`, set `wb_err`=0, go to RESP.
- RESP:
  - `wb_valid`=1. `wb_rd`, `wb_data` and `wb_err` are held until `wb_valid`&`wb_ready`, then go to IDLE.
- `cmp_c_valid` seen outside WAIT is ignored.
- One operation is in flight at a time. No new request is accepted in RESP.

## Timing
- Reset values: `req_ready` 0 while reset is asserted and 1 the cycle after release. `cmp_data_valid`, `wb_valid` and `wb_err` are 0. `cmp_*_data`, `cmp_op_data`, `wb_rd` and `wb_data` are 0. State is IDLE.
- Legal request accepted in cycle N:
  - ISSUE0 in N+1, ISSUE1 in N+2.
  - WAIT in N+3, when the compare unit asserts `cmp_c_valid`.
  - `wb_valid` in N+4.
  - Minimum spacing between accepts is 5 cycles with `wb_ready` tied high.
- Illegal funct accepted in cycle N: `wb_valid` in N+1.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all outputs at reset values.
  - The captured request and any pending result are discarded.
  - The compare unit shares `aresetn`, so it is cleared in the same cycle.
- `wb_ready` low: stall in RESP indefinitely; outputs stay bit-stable.

## Configuration
- `FPU_CMP_WATCHDOG_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - After `WDOG_CYC` WAIT cycles without `cmp_c_valid`, go to RESP with `wb_data`=0 and `wb_err`=1.
- Not defined: WAIT lasts until `cmp_c_valid`, with no limit. The counter and `WDOG_CYC` are absent.

## Structure
- Shared package `fpu_pkg`:
  - `cmp_op_t` enum (CMP_EQ=3'b000 … CMP_GT=3'b101).
  - Funct legality constants.
  - `cmp_issue_state_t` enum.
- One combinational sub-module, `fpu_cmp_decode`: maps funct to `cmp_op_t` and produces an illegal flag.
- The FSM, operand/tag registers and watchdog live in `fpu_cmp_issue`.

## Test plan
Benches use the real compare unit unless stated.
- Reset: hold `aresetn`=1 for 3 cycles → all outputs 0. Release → `req_ready`=1 on the next cycle.
- LT: rs1=0xBF800000, rs2=0x3F800000, funct=100, rd=7 at cycle N.
  - `cmp_data_valid` high only in N+1 and N+2, with `cmp_op_data`=100.
  - `wb_valid` in N+4 with `wb_rd`=7, `wb_data`=0x00000001, `wb_err`=0.
- EQ: rs1=0x00000000, rs2=0x80000000 (+0 vs −0) → `wb_data`=0x00000001.
- Illegal funct=111, rd=3 → `cmp_data_valid` never asserted; `wb_valid` in N+1 with `wb_data`=0, `wb_err`=1.
- Backpressure: hold `wb_ready`=0 for 4 cycles in RESP with a second `req_valid` pending.
  - `wb_*` stay stable and `req_ready`=0.
  - The second request is accepted the cycle after the writeback handshake.
- Abort and watchdog:
  - Reset asserted during ISSUE1 → `cmp_data_valid`=0 and state IDLE next cycle.
  - With `FPU_CMP_WATCHDOG_EN` and a stub that never asserts `cmp_c_valid` → `wb_valid`=1, `wb_err`=1, `wb_data`=0 after 8 WAIT cycles.
